craps_game_fsm: RTL
===================

Name: craps_game_fsm

Overview:
- Downstream consumer of the two dice roll counters.
- On each player roll request, samples both 3-bit dice values and forms their sum. Runs the craps rule state machine: come-out roll, point phase, win or lose.
- Drives registered game status (sum, point, win/lose, phase) to the display/LED stage.

Parameters:
- SUM_W, 4, width of the dice sum and point registers (covers 2..12).
- CNT_W, 8, width of the win/loss score counters (optional feature only).

Ports:
- clock  input  1  system clock shared with the dice counters.
- reset  input  1  synchronous, active-high reset.
- roll_btn  input  1  player roll request, level, already debounced. Only its rising edge is acted on.
- die_a  input  3  first die value, valid range 1..6.
- die_b  input  3  second die value, valid range 1..6.
- sum  output  SUM_W  last accepted roll total.
- point  output  SUM_W  established point; 0 when no point.
- win  output  1  high while in WIN.
- lose  output  1  high while in LOSE.
- point_phase  output  1  high while in POINT.
- bad_roll  output  1  one-cycle pulse: a roll edge arrived with a die value of 0 or 7.
- win_count  output  CNT_W  games won (optional feature).
- loss_count  output  CNT_W  games lost (optional feature).

Behaviour:
- Synchronous reset only, checked first on every posedge clock.
- Reset values: state=COMEOUT, sum=0, point=0, win=0, lose=0, point_phase=0, bad_roll=0, roll_q=0, counters=0.
- Reset mid-game abandons the game immediately. Counters clear.
- Edge detect:
  - roll_q <= roll_btn every cycle.
  - roll_edge = roll_btn & ~roll_q.
  - Holding roll_btn high yields exactly one roll.
- On the posedge where roll_edge=1, die_a and die_b are sampled. sum, state and all status outputs update at that same edge (one-edge latency, all outputs registered).
- Validity: if die_a or die_b is 0 or 7:
  - bad_roll=1 for one cycle.
  - state, sum, point and counters are unchanged.
- Arithmetic: sum = die_a + die_b, zero-extended to SUM_W. Never overflows (max 12).
- States are COMEOUT, POINT, WIN and LOSE. Transitions on a valid roll:
  - COMEOUT:
    - sum 7 or 11 -> WIN.
    - sum 2, 3 or 12 -> LOSE.
    - otherwise -> POINT, and point <= sum.
  - POINT:
    - sum == point -> WIN.
    - sum == 7 -> LOSE.
    - otherwise stay in POINT; point is held.
  - WIN or LOSE:
    - the roll is evaluated as the come-out roll of a new game, with the COMEOUT rules above.
    - point is cleared, or reloaded if the new roll sets a point.
- point is cleared to 0 on every entry to WIN or LOSE.
- win, lose and point_phase are decoded from the registered state and are mutually exclusive.
- No state change without roll_edge. Outputs hold indefinitely.

Optional Feature:
- Macro: CRAPS_SCORE_EN.
- Defined:
  - win_count increments on every entry to WIN; loss_count on every entry to LOSE.
  - Both saturate at all-ones; no wrap.
- Undefined:
  - win_count and loss_count are tied to 0.
  - No counter flops are synthesized.
  - Ports remain present.

Decomposition:
- Shared package craps_pkg holds:
  - state typedef (COMEOUT, POINT, WIN, LOSE).
  - SUM_W default.
  - Constants: SUM_SEVEN=7, SUM_ELEVEN=11, SUM_TWO=2, SUM_THREE=3, SUM_TWELVE=12.
  - Function is_valid_die.
- One sub-module: rise_edge_detect, a registered rising-edge detector with synchronous reset. It is also reusable for other button inputs.

Test Plan:
- Reset, then roll with die_a=3, die_b=4 -> edge cycle after: sum=7, win=1, point=0. With CRAPS_SCORE_EN: win_count=1.
- Come-out 1+1 -> sum=2, lose=1. Then roll 6+5 from LOSE -> sum=11, win=1 (new game).
- Come-out 2+2 -> point_phase=1, point=4. Then 3+3 -> stays POINT, point=4. Then 1+3 -> win=1, point=0.
- Come-out 5+5 -> point=10. Then 4+3 -> lose=1, point=0.
- roll_btn held high 10 cycles with dice changing -> exactly one roll evaluated. die_a=0 on an edge -> bad_roll pulses 1 cycle, state and sum unchanged.
- Reset asserted while in POINT (point=8) -> next edge: state COMEOUT, all outputs 0. Counters saturate at 255 after 300 forced wins (CNT_W=8).

Source files
------------

// File: rtl/craps_pkg.sv
// rtl/craps_pkg.sv - shared types, sizes and rule constants for the craps game block
package craps_pkg;

   // Game phase held in the rule state machine
   typedef enum logic [1:0] {
      COMEOUT = 2'd0,
      POINT   = 2'd1,
      WIN     = 2'd2,
      LOSE    = 2'd3
   } craps_state_t;

   // Default width of the sum/point registers; 4 bits hold 2..12
   localparam int DEF_SUM_W = 4;

   // Dice totals that decide a come-out roll
   localparam int SUM_TWO    = 2;
   localparam int SUM_THREE  = 3;
   localparam int SUM_SEVEN  = 7;
   localparam int SUM_ELEVEN = 11;
   localparam int SUM_TWELVE = 12;

   // A die face is usable only in 1..6; 0 and 7 flag a broken upstream counter
   function automatic logic is_valid_die(input logic [2:0] d);
      return (d != 3'd0) && (d != 3'd7);
   endfunction

endpackage

// File: rtl/rise_edge_detect.sv
// rtl/rise_edge_detect.sv - registered rising-edge detector for a debounced level input
module rise_edge_detect (
   input  logic clock,
   input  logic reset,
   input  logic sig_i,
   output logic rise_o
);

   logic sig_q;

   // Remember last cycle's level so a held input produces a single rise
   always_ff @(posedge clock) begin
      if (reset) begin
         sig_q <= 1'b0;
      end else begin
         sig_q <= sig_i;
      end
   end

   assign rise_o = sig_i & ~sig_q;

endmodule

// File: rtl/craps_game_fsm.sv
// rtl/craps_game_fsm.sv - craps rule state machine; CRAPS_SCORE_EN adds saturating win/loss counters
module craps_game_fsm
   import craps_pkg::*;
#(
   parameter int SUM_W = DEF_SUM_W,
   parameter int CNT_W = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             roll_btn,
   input  logic [2:0]       die_a,
   input  logic [2:0]       die_b,
   output logic [SUM_W-1:0] sum,
   output logic [SUM_W-1:0] point,
   output logic             win,
   output logic             lose,
   output logic             point_phase,
   output logic             bad_roll,
   output logic [CNT_W-1:0] win_count,
   output logic [CNT_W-1:0] loss_count
);

   craps_state_t     state_q, state_d;
   logic [SUM_W-1:0] sum_q, sum_d;
   logic [SUM_W-1:0] point_q, point_d;
   logic             bad_roll_q, bad_roll_d;

   logic             roll_edge;
   logic             dice_ok;
   logic             valid_roll;
   logic [SUM_W-1:0] roll_sum;

   rise_edge_detect u_roll_edge (
      .clock  (clock),
      .reset  (reset),
      .sig_i  (roll_btn),
      .rise_o (roll_edge)
   );

   assign dice_ok    = is_valid_die(die_a) && is_valid_die(die_b);
   assign valid_roll = roll_edge && dice_ok;
   assign roll_sum   = SUM_W'(die_a) + SUM_W'(die_b);

   // Rule evaluation: only a valid roll edge moves the game; bad dice just raise a flag
   always_comb begin
      state_d    = state_q;
      sum_d      = sum_q;
      point_d    = point_q;
      bad_roll_d = 1'b0;

      if (roll_edge && !dice_ok) begin
         bad_roll_d = 1'b1;
      end else if (valid_roll) begin
         sum_d = roll_sum;
         if (state_q == POINT) begin
            if (roll_sum == point_q) begin
               state_d = WIN;
               point_d = '0;
            end else if (roll_sum == SUM_W'(SUM_SEVEN)) begin
               state_d = LOSE;
               point_d = '0;
            end
         end else begin
            // COMEOUT, and a finished game whose next roll starts a fresh come-out
            if (roll_sum == SUM_W'(SUM_SEVEN) || roll_sum == SUM_W'(SUM_ELEVEN)) begin
               state_d = WIN;
               point_d = '0;
            end else if (roll_sum == SUM_W'(SUM_TWO) || roll_sum == SUM_W'(SUM_THREE) ||
                         roll_sum == SUM_W'(SUM_TWELVE)) begin
               state_d = LOSE;
               point_d = '0;
            end else begin
               state_d = POINT;
               point_d = roll_sum;
            end
         end
      end
   end

   // Game state and status registers
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= COMEOUT;
         sum_q      <= '0;
         point_q    <= '0;
         bad_roll_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         sum_q      <= sum_d;
         point_q    <= point_d;
         bad_roll_q <= bad_roll_d;
      end
   end

   assign sum         = sum_q;
   assign point       = point_q;
   assign bad_roll    = bad_roll_q;
   assign win         = (state_q == WIN);
   assign lose        = (state_q == LOSE);
   assign point_phase = (state_q == POINT);

`ifdef CRAPS_SCORE_EN
   logic [CNT_W-1:0] win_count_q;
   logic [CNT_W-1:0] loss_count_q;
   logic             enter_win;
   logic             enter_lose;

   // Every valid roll that lands in WIN/LOSE ends a game, even if the previous game ended the same way
   assign enter_win  = valid_roll && (state_d == WIN);
   assign enter_lose = valid_roll && (state_d == LOSE);

   // Saturating game tallies
   always_ff @(posedge clock) begin
      if (reset) begin
         win_count_q  <= '0;
         loss_count_q <= '0;
      end else begin
         if (enter_win && (win_count_q != '1)) begin
            win_count_q <= win_count_q + 1'b1;
         end
         if (enter_lose && (loss_count_q != '1)) begin
            loss_count_q <= loss_count_q + 1'b1;
         end
      end
   end

   assign win_count  = win_count_q;
   assign loss_count = loss_count_q;
`else
   assign win_count  = '0;
   assign loss_count = '0;
`endif

endmodule
